// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace serializer: the trace record layout, flag bit
// positions and the capture/transmit state encodings.
package cpu_trace_pkg;

  localparam int RECORD_BYTES = 6;
  localparam int BYTE_W       = 8;
  localparam int RECORD_W     = RECORD_BYTES * BYTE_W;
  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_BORROW  = 1;

  // pc sits in the top byte so the record shifts out MSB byte first
  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] opcode;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [7:0] result;
    logic [7:0] flags;
  } trace_rec_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_GAP
  } cap_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the trace serializer; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cpu_trace_serializer.sv
// Captures CPU result records into a FIFO and streams them as framed UART-style
// bytes on tx. Define TRACE_PARITY_EN to append an even-parity bit to each byte.
module cpu_trace_serializer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       result_ready,
  input  logic [7:0] pc_in,
  input  logic [7:0] opcode_in,
  input  logic [7:0] operand_a_in,
  input  logic [7:0] operand_b_in,
  input  logic [7:0] result_in,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic       next_out,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]        LAST_BYTE = 3'(RECORD_BYTES - 1);
`ifdef TRACE_PARITY_EN
  localparam tx_state_t AFTER_DATA = TX_PARITY;
`else
  localparam tx_state_t AFTER_DATA = TX_STOP;
`endif

  cap_state_t          cap_state, cap_next;
  logic [GAP_W-1:0]    gap_cnt;
  logic                wr_en;
  trace_rec_t          cap_rec;

  tx_state_t           tx_state, tx_next;
  logic [BAUD_W-1:0]   baud_cnt;
  logic                baud_wrap;
  logic [2:0]          bit_cnt;
  logic [2:0]          byte_idx;
  logic                pop;
  logic [RECORD_W-1:0] shift_reg;
  logic [RECORD_W-1:0] rd_data;
  logic [7:0]          cur_byte;
  logic                fifo_empty;

  always_comb begin
    cap_rec = '{pc: pc_in, opcode: opcode_in, operand_a: operand_a_in,
                operand_b: operand_b_in, result: result_in, flags: 8'h00};
    cap_rec.flags[FLAG_CARRY]  = carry_in;
    cap_rec.flags[FLAG_BORROW] = borrow_in;
  end

  trace_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (RECORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (cap_rec),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Capture side: acknowledge in the accepting cycle, then hold off for the gap
  always_comb begin
    cap_next = cap_state;
    wr_en    = 1'b0;
    case (cap_state)
      CAP_IDLE: begin
        if (result_ready && !fifo_full && !rst) begin
          wr_en    = 1'b1;
          cap_next = CAP_GAP;
        end
      end
      CAP_GAP: begin
        if (gap_cnt == GAP_LAST) cap_next = CAP_IDLE;
      end
      default: cap_next = CAP_IDLE;
    endcase
  end

  assign next_out = wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state <= CAP_IDLE;
      gap_cnt   <= '0;
    end else begin
      cap_state <= cap_next;
      if (cap_state == CAP_GAP && gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
      else                                             gap_cnt <= '0;
    end
  end

  // Transmit side: current byte is always the top byte of the shift register
  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign cur_byte  = shift_reg[RECORD_W-1 -: BYTE_W];
  assign busy      = !fifo_empty || (tx_state != TX_IDLE);

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    tx      = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          tx_next = TX_START;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (baud_wrap) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx = cur_byte[bit_cnt];
        if (baud_wrap && bit_cnt == 3'd7) tx_next = AFTER_DATA;
      end
`ifdef TRACE_PARITY_EN
      TX_PARITY: begin
        tx = even_parity(cur_byte);
        if (baud_wrap) tx_next = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (baud_wrap) begin
          if (byte_idx != LAST_BYTE) begin
            tx_next = TX_START;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            tx_next = TX_START;
          end else begin
            tx_next = TX_IDLE;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE || baud_wrap) baud_cnt <= '0;
      else                                  baud_cnt <= baud_cnt + 1'b1;
      if (tx_state == TX_DATA && baud_wrap) bit_cnt <= bit_cnt + 3'd1;
      if (pop)                                   byte_idx <= '0;
      else if (tx_state == TX_STOP && baud_wrap) byte_idx <= byte_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                                   shift_reg <= rd_data;
    else if (tx_state == TX_STOP && baud_wrap) shift_reg <= shift_reg << BYTE_W;
  end

endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Directed bench for cpu_trace_serializer (DEPTH=2, CLKS_PER_BIT=4, GAP_CYCLES=4);
// expected framing follows TRACE_PARITY_EN when it is defined.
module tb_cpu_trace_serializer;

  localparam int CPB   = 4;
  localparam int GAP   = 4;
`ifdef TRACE_PARITY_EN
  localparam int BPB   = 11;
`else
  localparam int BPB   = 10;
`endif
  localparam int REC_CYC = 6 * BPB * CPB;
  localparam logic [47:0] T1_REC = 48'h03_80_02_F6_F8_00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       result_ready = 1'b0;
  logic [7:0] pc_in = '0;
  logic [7:0] opcode_in = '0;
  logic [7:0] operand_a_in = '0;
  logic [7:0] operand_b_in = '0;
  logic [7:0] result_in = '0;
  logic       carry_in = 1'b0;
  logic       borrow_in = 1'b0;
  logic       next_out;
  logic       tx;
  logic       busy;
  logic       fifo_full;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulse_cyc [$];
  logic [47:0] fill_recs [4];
  logic [47:0] sim_recs [4];

  cpu_trace_serializer #(
    .DEPTH        (2),
    .CLKS_PER_BIT (CPB),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_ready (result_ready),
    .pc_in        (pc_in),
    .opcode_in    (opcode_in),
    .operand_a_in (operand_a_in),
    .operand_b_in (operand_b_in),
    .result_in    (result_in),
    .carry_in     (carry_in),
    .borrow_in    (borrow_in),
    .next_out     (next_out),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (next_out === 1'b1) pulse_cyc.push_back(cyc);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 50000", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [47:0] r, input int b);
    return r[47 - 8*b -: 8];
  endfunction

  task automatic set_inputs(input logic [47:0] r);
    pc_in        = r[47:40];
    opcode_in    = r[39:32];
    operand_a_in = r[31:24];
    operand_b_in = r[23:16];
    result_in    = r[15:8];
    carry_in     = r[0];
    borrow_in    = r[1];
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    @(negedge clk);
    while (next_out !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack"}, next_out, 1'b1);
  endtask

  task automatic send_record(input logic [47:0] r, input string tag);
    @(posedge clk); #2;
    set_inputs(r);
    result_ready = 1'b1;
    wait_ack(tag);
    @(posedge clk); #2;
    result_ready = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples each bit at mid-bit time.
  task automatic recv_byte(input logic [7:0] exp, input string tag, input int budget,
                           output int t_start);
    int n = 0;
    logic [7:0] got;
    got = '0;
    @(negedge clk);
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    t_start = cyc;
    chk({tag, "_sof"}, tx, 1'b0);
    if (tx !== 1'b0) return;
    repeat (CPB/2) @(negedge clk);
    chk({tag, "_start"}, tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      got[i] = tx;
    end
    chk({tag, "_data"}, got, exp);
`ifdef TRACE_PARITY_EN
    repeat (CPB) @(negedge clk);
    chk({tag, "_par"}, tx, ^exp);
`endif
    repeat (CPB) @(negedge clk);
    chk({tag, "_stop"}, tx, 1'b1);
  endtask

  initial begin
    int t0;
    int tdummy;
    int k0;
    int n;
    int target;
    int bad_tx;
    int bad_busy;
    logic [47:0] rec_a;
    logic [47:0] rec_b;

    t0 = 0; tdummy = 0; target = 0;
    fill_recs[0] = 48'h11_22_33_44_55_01;
    fill_recs[1] = 48'h07_F6_A5_5A_FF_02;
    fill_recs[2] = 48'h80_01_7E_00_C3_03;
    fill_recs[3] = 48'hDE_AD_BE_EF_12_00;
    sim_recs[0]  = 48'h0F_1E_2D_3C_4B_01;
    sim_recs[1]  = 48'hA1_B2_C3_D4_E5_02;
    sim_recs[2]  = 48'h07_70_00_FF_81_03;
    sim_recs[3]  = 48'hF6_6F_5A_A5_C6_00;

    // Reset with result_ready asserted: nothing may be acknowledged
    set_inputs(48'hAA_BB_CC_DD_EE_03);
    result_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_next_out", next_out, 1'b0);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    @(posedge clk); #2;
    result_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_busy", busy, 1'b0);
    chk("rel_next_out", next_out, 1'b0);

    // Single record: bytes, timing and one acknowledge
    k0 = pulse_cyc.size();
    send_record(T1_REC, "t1");
    for (int b = 0; b < 6; b++) begin
      recv_byte(byte_of(T1_REC, b), $sformatf("t1_b%0d", b), (b == 0) ? 40 : CPB/2, tdummy);
      if (b == 0) t0 = tdummy;
    end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_cycles", cyc - t0, REC_CYC);
    chk("t1_pulses", pulse_cyc.size() - k0, 1);
    chk("t1_tx_idle", tx, 1'b1);

    // result_ready held high: paced acks, FIFO fills, 4th waits for a pop
    k0 = pulse_cyc.size();
    fork
      begin
        @(posedge clk); #2;
        set_inputs(fill_recs[0]);
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          wait_ack($sformatf("t2_r%0d", i));
          @(posedge clk); #2;
          if (i < 3) set_inputs(fill_recs[i+1]);
          else       result_ready = 1'b0;
          if (i == 2) begin
            @(negedge clk);
            chk("t2_full", fifo_full, 1'b1);
          end
        end
      end
      begin
        for (int r = 0; r < 4; r++)
          for (int b = 0; b < 6; b++)
            recv_byte(byte_of(fill_recs[r], b), $sformatf("t2_r%0d_b%0d", r, b),
                      (r == 0 && b == 0) ? 40 : CPB/2, tdummy);
      end
    join
    chk("t2_pulses", pulse_cyc.size() - k0, 4);
    if (pulse_cyc.size() - k0 >= 4) begin
      chk("t2_gap01", pulse_cyc[k0+1] - pulse_cyc[k0], GAP + 1);
      chk("t2_gap12", pulse_cyc[k0+2] - pulse_cyc[k0+1], GAP + 1);
      chk("t2_gap03", pulse_cyc[k0+3] - pulse_cyc[k0], REC_CYC + 2);
    end

    // Reset during byte 2, data bit 4, with a second record queued
    repeat (20) @(negedge clk);
    rec_a = 48'h5A_3C_99_01_02_00;
    rec_b = 48'h12_34_56_78_9A_01;
    k0 = pulse_cyc.size();
    send_record(rec_a, "t3a");
    fork
      send_record(rec_b, "t3b");
      begin
        recv_byte(byte_of(rec_a, 0), "t3_b0", 40, tdummy);
        recv_byte(byte_of(rec_a, 1), "t3_b1", CPB/2, tdummy);
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < CPB/2) begin
          @(negedge clk);
          n++;
        end
        chk("t3_b2_sof", tx, 1'b0);
        repeat (CPB*5 + 1) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t3_rst_tx", tx, 1'b1);
        chk("t3_rst_busy", busy, 1'b0);
        chk("t3_rst_full", fifo_full, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
      end
    join
    bad_tx = 0;
    bad_busy = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("t3_resid_tx", bad_tx, 0);
    chk("t3_resid_busy", bad_busy, 0);
    chk("t3_pulses", pulse_cyc.size() - k0, 2);

    // Capture lands in the same cycle as a pop with one record queued
    k0 = pulse_cyc.size();
    fork
      begin
        @(posedge clk); #2;
        set_inputs(sim_recs[0]);
        result_ready = 1'b1;
        wait_ack("t4_x");
        @(posedge clk); #2;
        set_inputs(sim_recs[1]);
        wait_ack("t4_y");
        @(posedge clk); #2;
        result_ready = 1'b0;
        target = pulse_cyc[k0] + 1 + REC_CYC;
        while (cyc < target) begin
          @(posedge clk); #2;
        end
        set_inputs(sim_recs[2]);
        result_ready = 1'b1;
        @(negedge clk);
        chk("t4_z_ack", next_out, 1'b1);
        @(posedge clk); #2;
        set_inputs(sim_recs[3]);
        @(negedge clk);
        chk("t4_count1", fifo_full, 1'b0);
        wait_ack("t4_w");
        @(posedge clk); #2;
        result_ready = 1'b0;
        @(negedge clk);
        chk("t4_full", fifo_full, 1'b1);
      end
      begin
        for (int r = 0; r < 4; r++)
          for (int b = 0; b < 6; b++)
            recv_byte(byte_of(sim_recs[r], b), $sformatf("t4_r%0d_b%0d", r, b),
                      (r == 0 && b == 0) ? 40 : CPB/2, tdummy);
      end
    join
    chk("t4_pulses", pulse_cyc.size() - k0, 4);
    if (pulse_cyc.size() - k0 >= 4) begin
      chk("t4_gap_xz", pulse_cyc[k0+2] - pulse_cyc[k0], REC_CYC + 1);
      chk("t4_gap_zw", pulse_cyc[k0+3] - pulse_cyc[k0+2], GAP + 1);
    end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("end_busy", busy, 1'b0);
    chk("end_tx", tx, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
